// File: rtl/cbus_to_axi_pkg.sv
// Shared types for the CBus-to-AXI3 bridge: bus structs, burst encoding and FSM states.
// Optional B-channel wait is selected in the top with CBUS_AXI_BRESP_WAIT_EN.
package cbus_to_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    R    = 3'd2,
    AW   = 3'd3,
    W    = 3'd4,
    B    = 3'd5
  } state_e;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  typedef struct packed {
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        bready;
  } axi_req_t;

  typedef struct packed {
    logic        arready;
    logic        awready;
    logic        wready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
  } axi_resp_t;

endpackage

// File: rtl/cbus_to_axi.sv
// CBus to AXI3 master bridge, one outstanding transaction, flat FSM plus beat counter.
// Define CBUS_AXI_BRESP_WAIT_EN to hold the final cresp.last until the B response.
module cbus_to_axi
  import cbus_to_axi_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'h0
) (
  input  logic       clk,
  input  logic       resetn,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp,
  output axi_req_t   axi_req,
  input  axi_resp_t  axi_resp
);

  state_e     state_r;
  state_e     state_s;
  logic [3:0] beat_cnt_r;
  logic       wlast_s;
  logic       unused_s;

  assign wlast_s = (beat_cnt_r == creq.len);

  // Response codes and IDs never alter the data path.
`ifdef CBUS_AXI_BRESP_WAIT_EN
  assign unused_s = ^{axi_resp.rid, axi_resp.rresp, axi_resp.bid, axi_resp.bresp};
`else
  assign unused_s = ^{axi_resp.rid, axi_resp.rresp, axi_resp.bid, axi_resp.bresp,
                      axi_resp.bvalid};
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Write beat counter: cleared during AW, saturates at creq.len
  always_ff @(posedge clk) begin
    if (!resetn) begin
      beat_cnt_r <= 4'd0;
    end else if (state_r == AW) begin
      beat_cnt_r <= 4'd0;
    end else if ((state_r == W) && axi_resp.wready && !wlast_s) begin
      beat_cnt_r <= beat_cnt_r + 4'd1;
    end else begin
      beat_cnt_r <= beat_cnt_r;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (creq.valid) begin
          state_s = creq.is_write ? AW : AR;
        end else begin
          state_s = IDLE;
        end
      end
      AR: state_s = axi_resp.arready ? R : AR;
      R:  state_s = (axi_resp.rvalid && axi_resp.rlast) ? IDLE : R;
      AW: state_s = axi_resp.awready ? W : AW;
      W: begin
        if (axi_resp.wready && wlast_s) begin
`ifdef CBUS_AXI_BRESP_WAIT_EN
          state_s = B;
`else
          state_s = IDLE;
`endif
        end else begin
          state_s = W;
        end
      end
`ifdef CBUS_AXI_BRESP_WAIT_EN
      B:  state_s = axi_resp.bvalid ? IDLE : B;
`endif
      default: state_s = IDLE;
    endcase
  end

  // Output decode; payload comes straight from creq, which upstream holds stable
  always_comb begin
    axi_req         = '0;
    axi_req.arid    = AXI_ID;
    axi_req.awid    = AXI_ID;
    axi_req.wid     = AXI_ID;
    axi_req.araddr  = creq.addr;
    axi_req.arlen   = creq.len;
    axi_req.arsize  = creq.size;
    axi_req.arburst = AXI_BURST_INCR;
    axi_req.awaddr  = creq.addr;
    axi_req.awlen   = creq.len;
    axi_req.awsize  = creq.size;
    axi_req.awburst = AXI_BURST_INCR;
    axi_req.wdata   = creq.data;
    axi_req.wstrb   = creq.strobe;
`ifdef CBUS_AXI_BRESP_WAIT_EN
    axi_req.bready  = (state_r == B);
`else
    axi_req.bready  = 1'b1;
`endif
    cresp           = '0;
    case (state_r)
      AR: axi_req.arvalid = 1'b1;
      R: begin
        axi_req.rready = 1'b1;
        cresp.ready    = axi_resp.rvalid;
        cresp.last     = axi_resp.rvalid & axi_resp.rlast;
        cresp.data     = axi_resp.rdata;
      end
      AW: axi_req.awvalid = 1'b1;
      W: begin
        axi_req.wvalid = 1'b1;
        axi_req.wlast  = wlast_s;
        if (axi_resp.wready) begin
          cresp.ready = 1'b1;
`ifdef CBUS_AXI_BRESP_WAIT_EN
          cresp.last  = 1'b0;
`else
          cresp.last  = wlast_s;
`endif
        end else begin
          cresp.ready = 1'b0;
        end
      end
`ifdef CBUS_AXI_BRESP_WAIT_EN
      B: cresp.last = axi_resp.bvalid;
`endif
      default: cresp = '0;
    endcase
  end

endmodule

// File: tb/tb_cbus_to_axi.sv
// Directed self-checking bench for cbus_to_axi; honours CBUS_AXI_BRESP_WAIT_EN.
module tb_cbus_to_axi;
  import cbus_to_axi_pkg::*;

  logic       clk;
  logic       resetn;
  cbus_req_t  creq;
  cbus_resp_t cresp;
  axi_req_t   axi_req;
  axi_resp_t  axi_resp;

  int errors = 0;
  int checks = 0;

  cbus_to_axi #(.AXI_ID(4'h0)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .creq    (creq),
    .cresp   (cresp),
    .axi_req (axi_req),
    .axi_resp(axi_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " state"}, 32'(dut.state_r), 32'(IDLE));
    chk({tag, " valids"}, {28'd0, axi_req.arvalid, axi_req.awvalid, axi_req.wvalid,
                           axi_req.rready}, 32'd0);
    chk({tag, " cresp"}, {30'd0, cresp.ready, cresp.last}, 32'd0);
    chk({tag, " cdata"}, cresp.data, 32'd0);
  endtask

  // Single-beat read with arready at once and rdata two cycles after acceptance
  task automatic single_read(input string tag, input logic [31:0] addr, input logic [31:0] data);
    creq = '0;
    creq.valid = 1'b1;
    creq.addr = addr;
    creq.size = 3'd2;
    creq.len = 4'd0;
    axi_resp.arready = 1'b1;
    #1;
    chk({tag, " latency arvalid"}, {31'd0, axi_req.arvalid}, 32'd0);
    tick();
    chk({tag, " arvalid"}, {31'd0, axi_req.arvalid}, 32'd1);
    chk({tag, " araddr"}, axi_req.araddr, addr);
    chk({tag, " arlen/size/burst/id"}, {19'd0, axi_req.arid, axi_req.arlen, axi_req.arsize,
                                        axi_req.arburst}, {19'd0, 4'h0, 4'd0, 3'd2, 2'b01});
    chk({tag, " no cresp in AR"}, {31'd0, cresp.ready}, 32'd0);
    tick();
    axi_resp.arready = 1'b0;
    #1;
    chk({tag, " rready"}, {31'd0, axi_req.rready}, 32'd1);
    chk({tag, " arvalid dropped"}, {31'd0, axi_req.arvalid}, 32'd0);
    chk({tag, " no cresp wait"}, {31'd0, cresp.ready}, 32'd0);
    tick();
    axi_resp.rvalid = 1'b1;
    axi_resp.rlast = 1'b1;
    axi_resp.rdata = data;
    axi_resp.rresp = 2'b10;
    #1;
    chk({tag, " ready/last"}, {30'd0, cresp.ready, cresp.last}, 32'd3);
    chk({tag, " data"}, cresp.data, data);
    tick();
    axi_resp.rvalid = 1'b0;
    axi_resp.rlast = 1'b0;
    axi_resp.rdata = 32'd0;
    axi_resp.rresp = 2'b00;
    creq.valid = 1'b0;
    #1;
    chk_idle({tag, " done"});
  endtask

  initial begin
    int beat;
    int pulses;
    logic [31:0] rdat [4];
    rdat[0] = 32'h1111_0001;
    rdat[1] = 32'h2222_0002;
    rdat[2] = 32'h3333_0003;
    rdat[3] = 32'h4444_0004;

    creq = '0;
    axi_resp = '0;
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    #1;
    chk_idle("reset");
`ifdef CBUS_AXI_BRESP_WAIT_EN
    chk("reset bready", {31'd0, axi_req.bready}, 32'd0);
`else
    chk("reset bready", {31'd0, axi_req.bready}, 32'd1);
`endif

    single_read("rd1", 32'h1fc0_0000, 32'hdeadbeef);

    // 4-beat read: arready withheld 10 cycles, then rvalid every other cycle
    creq = '0;
    creq.valid = 1'b1;
    creq.addr = 32'h8000_0010;
    creq.size = 3'd2;
    creq.len = 4'd3;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("rd4 arvalid held", {31'd0, axi_req.arvalid}, 32'd1);
      chk("rd4 araddr stable", axi_req.araddr, 32'h8000_0010);
      chk("rd4 arlen", {28'd0, axi_req.arlen}, 32'd3);
      chk("rd4 no cresp", {30'd0, cresp.ready, cresp.last}, 32'd0);
      tick();
    end
    axi_resp.arready = 1'b1;
    #1;
    chk("rd4 arvalid at ready", {31'd0, axi_req.arvalid}, 32'd1);
    tick();
    axi_resp.arready = 1'b0;
    beat = 0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      axi_resp.rvalid = (i % 2 == 1);
      axi_resp.rdata = (i % 2 == 1) ? rdat[beat] : 32'hbad0_0000;
      axi_resp.rlast = (i == 7);
      #1;
      chk("rd4 ready", {31'd0, cresp.ready}, {31'd0, (i % 2 == 1)});
      chk("rd4 last", {31'd0, cresp.last}, {31'd0, (i == 7)});
      if (cresp.ready) begin
        pulses++;
        chk("rd4 data", cresp.data, rdat[beat]);
        beat++;
      end
      tick();
    end
    chk("rd4 pulse count", 32'(pulses), 32'd4);
    axi_resp.rvalid = 1'b0;
    axi_resp.rlast = 1'b0;
    creq.valid = 1'b0;
    #1;
    chk_idle("rd4 done");

    // 4-beat write, random wready, data 1..4
    creq = '0;
    creq.valid = 1'b1;
    creq.is_write = 1'b1;
    creq.addr = 32'h0000_0100;
    creq.size = 3'd2;
    creq.len = 4'd3;
    creq.strobe = 4'hf;
    creq.data = 32'd1;
    tick();
    axi_resp.awready = 1'b1;
    #1;
    chk("wr4 awvalid", {31'd0, axi_req.awvalid}, 32'd1);
    chk("wr4 aw fields", {axi_req.awaddr[27:0], axi_req.awlen}, {28'h000_0100, 4'd3});
    chk("wr4 awburst/size", {27'd0, axi_req.awburst, axi_req.awsize}, {27'd0, 2'b01, 3'd2});
    tick();
    axi_resp.awready = 1'b0;
    beat = 0;
    pulses = 0;
    for (int i = 0; i < 60 && beat < 4; i++) begin
      creq.data = 32'(beat + 1);
      axi_resp.wready = (i > 30) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      chk("wr4 wvalid", {31'd0, axi_req.wvalid}, 32'd1);
      chk("wr4 wdata", axi_req.wdata, 32'(beat + 1));
      chk("wr4 wstrb", {28'd0, axi_req.wstrb}, 32'hf);
      chk("wr4 wlast", {31'd0, axi_req.wlast}, {31'd0, (beat == 3)});
      chk("wr4 cready", {31'd0, cresp.ready}, {31'd0, axi_resp.wready});
`ifdef CBUS_AXI_BRESP_WAIT_EN
      chk("wr4 clast", {31'd0, cresp.last}, 32'd0);
`else
      chk("wr4 clast", {31'd0, cresp.last}, {31'd0, (axi_resp.wready && beat == 3)});
`endif
      if (axi_resp.wready) begin
        pulses++;
        beat++;
      end
      tick();
    end
    chk("wr4 pulse count", 32'(pulses), 32'd4);
    axi_resp.wready = 1'b0;
`ifdef CBUS_AXI_BRESP_WAIT_EN
    axi_resp.bvalid = 1'b1;
    #1;
    chk("wr4 B last", {30'd0, cresp.ready, cresp.last}, 32'd1);
    tick();
    axi_resp.bvalid = 1'b0;
`endif
    creq.valid = 1'b0;
    #1;
    chk_idle("wr4 done");

    // Single write, bvalid 5 cycles after the final W beat
    creq = '0;
    creq.valid = 1'b1;
    creq.is_write = 1'b1;
    creq.addr = 32'h0000_0200;
    creq.size = 3'd2;
    creq.strobe = 4'h3;
    creq.data = 32'ha5a5_a5a5;
    tick();
    axi_resp.awready = 1'b1;
    tick();
    axi_resp.awready = 1'b0;
    axi_resp.wready = 1'b1;
    #1;
    chk("wr1 wlast", {31'd0, axi_req.wlast}, 32'd1);
    chk("wr1 wdata", axi_req.wdata, 32'ha5a5_a5a5);
`ifdef CBUS_AXI_BRESP_WAIT_EN
    chk("wr1 final beat", {30'd0, cresp.ready, cresp.last}, 32'd2);
`else
    chk("wr1 final beat", {30'd0, cresp.ready, cresp.last}, 32'd3);
`endif
    tick();
    axi_resp.wready = 1'b0;
`ifdef CBUS_AXI_BRESP_WAIT_EN
    for (int k = 1; k <= 5; k++) begin
      axi_resp.bvalid = (k == 5);
      axi_resp.bresp = 2'b11;
      #1;
      chk("wr1 bready", {31'd0, axi_req.bready}, 32'd1);
      chk("wr1 B cresp", {30'd0, cresp.ready, cresp.last}, {30'd0, 1'b0, (k == 5)});
      tick();
    end
    axi_resp.bvalid = 1'b0;
`else
    chk("wr1 bready", {31'd0, axi_req.bready}, 32'd1);
`endif
    creq.valid = 1'b0;
    #1;
    chk_idle("wr1 done");

    // Reset during the third beat of a 4-beat read, then a fresh read
    creq = '0;
    creq.valid = 1'b1;
    creq.addr = 32'h0000_0300;
    creq.size = 3'd2;
    creq.len = 4'd3;
    axi_resp.arready = 1'b1;
    tick();
    tick();
    axi_resp.arready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      axi_resp.rvalid = 1'b1;
      axi_resp.rdata = rdat[i];
      resetn = (i != 2);
      #1;
      chk("rst rd beat", {30'd0, cresp.ready, cresp.last}, 32'd2);
      chk("rst rd data", cresp.data, rdat[i]);
      tick();
    end
    creq.valid = 1'b0;
    #1;
    chk_idle("rst abandoned");
    resetn = 1'b1;
    axi_resp.rvalid = 1'b0;
    axi_resp.rdata = 32'd0;
    #1;
    chk_idle("rst released");
    single_read("rd after rst", 32'h0000_0400, 32'hcafe_f00d);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
